// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory alucodes, write-strobe
// width, FSM state encoding and small alucode classification helpers.
package load_store_unit_pkg;

    localparam int MEM_STRB_W = 4;

    localparam logic [5:0] ALU_LB  = 6'h10;
    localparam logic [5:0] ALU_LH  = 6'h11;
    localparam logic [5:0] ALU_LW  = 6'h12;
    localparam logic [5:0] ALU_LBU = 6'h13;
    localparam logic [5:0] ALU_LHU = 6'h14;
    localparam logic [5:0] ALU_SB  = 6'h15;
    localparam logic [5:0] ALU_SH  = 6'h16;
    localparam logic [5:0] ALU_SW  = 6'h17;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_load_op(input logic [5:0] code);
        return code inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_store_op(input logic [5:0] code);
        return code inside {ALU_SB, ALU_SH, ALU_SW};
    endfunction

    function automatic logic is_mem_op(input logic [5:0] code);
        return is_load_op(code) || is_store_op(code);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (code)
            ALU_LH, ALU_LHU, ALU_SH: mis = lo[0];
            ALU_LW, ALU_SW:          mis = (lo != 2'b00);
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus.
//   req/we/addr/wdata/wstrb : request side, driven by the master (LSU)
//   gnt                     : request accepted this cycle
//   rvalid/rdata            : response (load data or store ack)
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  req;
    logic                  we;
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wdata;
    logic [MEM_STRB_W-1:0] wstrb;
    logic                  gnt;
    logic                  rvalid;
    logic [XLEN-1:0]       rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: combinational byte-lane steering.
//   alucode, addr_lo, sdata -> wstrb, wdata (lane-replicated store data)
//   alucode, addr_lo, rdata -> ldata (sign/zero-extended load data, 0 for stores)
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]            alucode,
    input  logic [1:0]            addr_lo,
    input  logic [XLEN-1:0]       sdata,
    input  logic [XLEN-1:0]       rdata,
    output logic [MEM_STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       ldata
);
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;

    always_comb begin
        byte_sh = rdata >> {addr_lo, 3'b000};
        half_sh = rdata >> {addr_lo[1], 4'b0000};
        wstrb   = '0;
        wdata   = '0;
        ldata   = '0;
        case (alucode)
            ALU_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            ALU_SH: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            ALU_SW: begin
                wstrb = '1;
                wdata = sdata;
            end
            ALU_LB:  ldata = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            ALU_LBU: ldata = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            ALU_LH:  ldata = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            ALU_LHU: ldata = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            ALU_LW:  ldata = rdata;
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage behind the ALU. Accepts one memory op at a
// time, runs it over the req/gnt/rvalid bus and returns a one-cycle
// writeback pulse (load data or store completion, or a misalignment exception).
//   clk, rst_n          : clock, synchronous active-low reset
//   in_*                : op from the ALU (valid/ready handshake)
//   flush               : squash the in-flight op
//   mem                 : data-memory bus (master side)
//   wb_*, exc_misaligned: writeback result
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_alucode,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_sdata,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    load_store_unit_if.master mem,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_misaligned
);
    lsu_state_t state, state_nx;

    logic [5:0]            op_code;
    logic [XLEN-1:0]       op_addr;
    logic [XLEN-1:0]       op_sdata;
    logic [RD_W-1:0]       op_rd;
    logic                  op_mis;
    logic                  squashed;
    logic [XLEN-1:0]       wb_data_q;
    logic                  accept;
    logic [MEM_STRB_W-1:0] al_wstrb;
    logic [XLEN-1:0]       al_wdata;
    logic [XLEN-1:0]       al_ldata;

    // Non-memory alucodes and ops arriving with flush are never accepted.
    assign accept = (state == LSU_IDLE) && in_valid && !flush && is_mem_op(in_alucode);

    lsu_align #(.XLEN(XLEN)) u_align (
        .alucode (op_code),
        .addr_lo (op_addr[1:0]),
        .sdata   (op_sdata),
        .rdata   (mem.rdata),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ldata   (al_ldata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LSU_IDLE: if (accept)
                          state_nx = is_misaligned(in_alucode, in_addr[1:0]) ? LSU_RESP : LSU_REQ;
            // gnt beats a simultaneous flush: the access is already issued.
            LSU_REQ:  if (mem.gnt)    state_nx = LSU_WAIT;
                      else if (flush) state_nx = LSU_IDLE;
            // An issued access must still drain its response before going idle.
            LSU_WAIT: if (mem.rvalid) state_nx = (squashed || flush) ? LSU_IDLE : LSU_RESP;
            LSU_RESP: state_nx = LSU_IDLE;
            default:  state_nx = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_code   <= '0;
            op_addr   <= '0;
            op_sdata  <= '0;
            op_rd     <= '0;
            op_mis    <= 1'b0;
            squashed  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            if (accept) begin
                op_code   <= in_alucode;
                op_addr   <= in_addr;
                op_sdata  <= in_sdata;
                op_rd     <= in_rd;
                op_mis    <= is_misaligned(in_alucode, in_addr[1:0]);
                squashed  <= 1'b0;
                wb_data_q <= '0;
            end
            if (state == LSU_WAIT && flush) squashed <= 1'b1;
            if (state == LSU_WAIT && mem.rvalid) wb_data_q <= al_ldata;
        end
    end

    always_comb begin
        in_ready       = (state == LSU_IDLE);
        mem.req        = (state == LSU_REQ);
        mem.we         = is_store_op(op_code);
        mem.addr       = {op_addr[XLEN-1:2], 2'b00};
        mem.wdata      = al_wdata;
        mem.wstrb      = al_wstrb;
        wb_valid       = (state == LSU_RESP) && !flush;
        wb_we          = wb_valid && is_load_op(op_code) && (op_rd != '0) && !op_mis;
        wb_rd          = op_rd;
        wb_data        = wb_data_q;
        exc_misaligned = wb_valid && op_mis;
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_alucode;
    logic [31:0] in_addr;
    logic [31:0] in_sdata;
    logic [4:0]  in_rd;
    logic        flush;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        exc;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    load_store_unit_if #(.XLEN(32)) mem_bus ();

    load_store_unit #(.XLEN(32), .RD_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alucode     (in_alucode),
        .in_addr        (in_addr),
        .in_sdata       (in_sdata),
        .in_rd          (in_rd),
        .flush          (flush),
        .mem            (mem_bus),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Writeback monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("exc_misaligned", {31'd0, exc_misaligned}, {31'd0, e.exc});
                if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
                else           chk("mis_latency_le2", {31'd0, (cyc - e.t0) <= 2}, 32'd1);
            end
        end
    end

    task automatic count_wb(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (wb_valid) c++;
        end
    endtask

    // Issue one op, act as memory (gnt after gnt_wait idle cycles, rvalid next
    // cycle) and wait for the scoreboard to drain.
    task automatic run_op(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input int gnt_wait,
                          input logic mis, input logic [31:0] exp_data, input logic exp_wbwe,
                          input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
        exp_t e;
        logic [31:0] a0;
        int reqs;
        bit done;
        in_valid = 1'b1; in_alucode = code; in_addr = addr; in_sdata = sdata; in_rd = rd;
        e.rd = rd; e.data = exp_data; e.we = exp_wbwe; e.exc = mis; e.t0 = cyc;
        e.lat = mis ? 0 : 3 + gnt_wait;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        if (mis) begin
            reqs = 0;
            for (int i = 0; i < 4; i++) begin
                if (mem_bus.req) reqs++;
                tick();
            end
            chk("mis_no_req", reqs, 0);
        end else begin
            chk("req", {31'd0, mem_bus.req}, 32'd1);
            chk("mem_addr", mem_bus.addr, exp_maddr);
            chk("mem_we", {31'd0, mem_bus.we}, {31'd0, is_store_op(code)});
            chk("mem_wstrb", {28'd0, mem_bus.wstrb}, {28'd0, exp_strb});
            if (exp_strb != 4'b0000) chk("mem_wdata", mem_bus.wdata, exp_wdata);
            a0 = mem_bus.addr;
            for (int i = 0; i < gnt_wait; i++) begin
                tick();
                chk("req_hold", {31'd0, mem_bus.req}, 32'd1);
                chk("addr_hold", mem_bus.addr, a0);
            end
            mem_bus.gnt = 1'b1;
            tick();
            mem_bus.gnt = 1'b0;
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata = rdata;
            tick();
            mem_bus.rvalid = 1'b0;
            mem_bus.rdata = 32'h0;
        end
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (sb.size() == 0) done = 1;
            else tick();
        end
        if (!done) begin
            chk("wb_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst_n = 1'b0; in_valid = 1'b0; in_alucode = '0; in_addr = '0; in_sdata = '0; in_rd = '0;
        flush = 1'b0; mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req", {31'd0, mem_bus.req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_bus.we}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_exc", {31'd0, exc_misaligned}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        tick();

        //      code     addr        sdata        rd    rdata         gw mis exp_data      we   maddr        strb     wdata
        run_op(ALU_LB,  32'h103, 32'h0,        5'd5, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 1, 32'h100, 4'b0000, 32'h0);
        run_op(ALU_LHU, 32'h102, 32'h0,        5'd6, 32'hBEEF1234, 0, 0, 32'h0000BEEF, 1, 32'h100, 4'b0000, 32'h0);
        run_op(ALU_LH,  32'h102, 32'h0,        5'd7, 32'hBEEF1234, 0, 0, 32'hFFFFBEEF, 1, 32'h100, 4'b0000, 32'h0);
        run_op(ALU_SB,  32'h101, 32'h000000AB, 5'd3, 32'h0,        0, 0, 32'h0,        0, 32'h100, 4'b0010, 32'hABABABAB);
        run_op(ALU_LW,  32'h102, 32'h0,        5'd8, 32'h0,        0, 1, 32'h0,        0, 32'h0,   4'b0000, 32'h0);
        run_op(ALU_SH,  32'h101, 32'h1234,     5'd9, 32'h0,        0, 1, 32'h0,        0, 32'h0,   4'b0000, 32'h0);
        run_op(ALU_SW,  32'h104, 32'hDEADBEEF, 5'd1, 32'h0,        3, 0, 32'h0,        0, 32'h104, 4'b1111, 32'hDEADBEEF);
        run_op(ALU_LBU, 32'h101, 32'h0,        5'd2, 32'h80FF1234, 1, 0, 32'h00000012, 1, 32'h100, 4'b0000, 32'h0);
        run_op(ALU_SH,  32'h102, 32'h1234ABCD, 5'd4, 32'h0,        0, 0, 32'h0,        0, 32'h100, 4'b1100, 32'hABCDABCD);
        run_op(ALU_LW,  32'h108, 32'h0,        5'd0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 32'h108, 4'b0000, 32'h0);

        // Flush in the second REQ cycle while gnt is held low.
        in_valid = 1'b1; in_alucode = ALU_LW; in_addr = 32'h300; in_rd = 5'd9;
        tick();
        in_valid = 1'b0;
        chk("flreq_req1", {31'd0, mem_bus.req}, 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flreq_req_drop", {31'd0, mem_bus.req}, 32'd0);
        chk("flreq_in_ready", {31'd0, in_ready}, 32'd1);
        count_wb(4, c);
        chk("flreq_no_wb", c, 0);

        // Flush in WAIT: the response is drained but not written back.
        in_valid = 1'b1; in_alucode = ALU_LW; in_addr = 32'h304; in_rd = 5'd9;
        tick();
        in_valid = 1'b0;
        mem_bus.gnt = 1'b1;
        tick();
        mem_bus.gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flwait_busy", {31'd0, in_ready}, 32'd0);
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h55555555;
        tick();
        mem_bus.rvalid = 1'b0;
        chk("flwait_in_ready", {31'd0, in_ready}, 32'd1);
        count_wb(4, c);
        chk("flwait_no_wb", c, 0);

        // Flush coinciding with in_valid: op refused.
        in_valid = 1'b1; flush = 1'b1; in_alucode = ALU_LW; in_addr = 32'h308;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flacc_no_req", {31'd0, mem_bus.req}, 32'd0);
        chk("flacc_in_ready", {31'd0, in_ready}, 32'd1);

        // Non-memory alucode is dropped.
        in_valid = 1'b1; in_alucode = 6'h00; in_addr = 32'h400;
        tick();
        in_valid = 1'b0;
        chk("nonmem_in_ready", {31'd0, in_ready}, 32'd1);
        chk("nonmem_no_req", {31'd0, mem_bus.req}, 32'd0);

        // Reset while in WAIT; the late response must be ignored.
        in_valid = 1'b1; in_alucode = ALU_LW; in_addr = 32'h500; in_rd = 5'd4;
        tick();
        in_valid = 1'b0;
        mem_bus.gnt = 1'b1;
        tick();
        mem_bus.gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstwait_in_ready", {31'd0, in_ready}, 32'd1);
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hFFFFFFFF;
        tick();
        mem_bus.rvalid = 1'b0;
        count_wb(4, c);
        chk("rstwait_no_wb", c, 0);
        run_op(ALU_LW, 32'h200, 32'h0, 5'd0, 32'h12345678, 0, 0, 32'h12345678, 0, 32'h200, 4'b0000, 32'h0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage placed directly downstream of the ALU in the superscalar pipeline.
- Consumes the ALU's effective address (alu_result for ALU_LB..ALU_SW) together with the alucode, store data and destination register.
- Runs one data-memory transaction over a req/gnt/rvalid handshake, then returns either a load value or a store completion to writeback.
- Single outstanding access. Byte-lane steering, write strobes, sign/zero extension and misalignment detection are all done inside the block.

Parameters:
XLEN, 32, data/address width; only 32 is supported
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ALU result carrying a memory op is present
in_ready  out  1  unit can accept an op (high only in IDLE)
in_alucode  in  6  ALU_LB/LH/LW/LBU/LHU/SB/SH/SW from define.vh
in_addr  in  XLEN  effective address (ALU result)
in_sdata  in  XLEN  store data (rs2 value)
in_rd  in  RD_W  load destination register
flush  in  1  squash the in-flight op (mispredict)
mem_req  out  1  memory request; held until granted
mem_we  out  1  1 = store
mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  XLEN  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response valid (loads: data; stores: ack)
mem_rdata  in  XLEN  read word
wb_valid  out  1  one-cycle completion pulse
wb_we  out  1  register write enable (load and rd != 0)
wb_rd  out  RD_W  destination register
wb_data  out  XLEN  extended load data (0 for stores)
exc_misaligned  out  1  qualifies wb_valid: access was misaligned

Behaviour:
- Reset: clk and rst_n only; reset is synchronous and active-low. On a clock edge with rst_n low, the state goes to IDLE and all outputs, wb_* and exc_misaligned are cleared to 0, except in_ready, which is 1 once in IDLE. This applies in any state. A memory response arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - An op is accepted on in_valid && in_ready and its fields are latched.
  - Ops whose alucode is not a memory alucode are dropped; in_ready stays 1.
- Misalignment check:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, is misaligned.
  - Misaligned ops go straight to RESP. No mem_req is issued.
  - In RESP: wb_valid = 1, exc_misaligned = 1, wb_we = 0.
- REQ: mem_req = 1 with stable addr/we/wdata/wstrb until mem_gnt. On gnt, go to WAIT (mem_req drops the next cycle).
- WAIT: on mem_rvalid, latch the extended data and go to RESP. The earliest mem_rvalid is the cycle after gnt; mem_rvalid seen in the gnt cycle itself is ignored.
- RESP: wb_valid is high for exactly one cycle, then the FSM returns to IDLE. No writeback backpressure.
- Minimum latency: accept at T, req+gnt at T+1, rvalid at T+2, wb_valid at T+3.
- Store encoding:
  - SB: wstrb = 1 << addr[1:0], wdata = {4{sdata[7:0]}}.
  - SH: wstrb = 0011 or 1100 by addr[1], wdata = {2{sdata[15:0]}}.
  - SW: wstrb = 1111, wdata = sdata.
  - Loads: wstrb = 0000.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- wb_we = 1 only for loads with rd != 0 and no exception.
- Flush:
  - In IDLE or REQ (gnt not yet seen): abort to IDLE next cycle. No wb_valid. mem_req drops.
  - If flush and gnt fall in the same cycle, gnt wins: the access is considered issued.
  - In WAIT: still wait for rvalid, then return to IDLE with no wb_valid.
  - In RESP: suppress wb_valid.
- flush together with in_valid in IDLE: the op is not accepted.

Decomposition:
- ALU_* alucode constants and ENABLE/DISABLE stay in the shared define.vh.
- Add shared constants LSU_IDLE/LSU_REQ/LSU_WAIT/LSU_RESP (2-bit) and MEM_STRB_W = 4 to define.vh.
- One natural combinational sub-module: lsu_align. It produces wstrb/wdata from alucode, addr and sdata, and the extended load data from alucode, addr and rdata. The FSM stays in load_store_unit.

Test Plan:
- LB, addr 0x103, rdata 0x80FF1234, gnt at T+1, rvalid at T+2 -> wb_valid at T+3, wb_data 0xFFFFFF80, wb_we = 1.
- LHU, addr 0x102, rdata 0xBEEF1234 -> wb_data 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- SB, addr 0x101, sdata 0x000000AB -> mem_we = 1, mem_addr 0x100, wstrb 0010, wdata 0xABABABAB; after ack, wb_valid = 1, wb_we = 0.
- LW at 0x102 -> no mem_req ever; wb_valid = 1 and exc_misaligned = 1 two cycles after accept. SH at 0x101 behaves the same.
- gnt held low for 3 cycles -> mem_req and mem_addr stable throughout. Flush in the 2nd cycle -> mem_req drops, no wb_valid, in_ready = 1.
- rst_n low for one cycle while in WAIT -> IDLE, no wb_valid when the late rvalid arrives; the next LW at 0x200 (rdata 0x12345678) completes with wb_data 0x12345678 and rd = 0 giving wb_we = 0.
